// File: rtl/out_triple_serializer_pkg.sv
// out_triple_serializer_pkg
// Shared types and constants for the triple serializer:
//   - ser_state_t : serializer state encoding (IDLE, SEND1..SEND3)
//   - IDX_*       : word_idx encodings (0 = idle, 1..3 = source bus)
//   - triple_t    : one captured 96-bit value triple (out1 in the MSBs)
package out_triple_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND1 = 2'd1,
    S_SEND2 = 2'd2,
    S_SEND3 = 2'd3
  } ser_state_t;

  localparam logic [1:0] IDX_NONE = 2'd0;
  localparam logic [1:0] IDX_1    = 2'd1;
  localparam logic [1:0] IDX_2    = 2'd2;
  localparam logic [1:0] IDX_3    = 2'd3;

  typedef struct packed {
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] out3;
  } triple_t;

endpackage

// File: rtl/out_triple_serializer_triple_fifo.sv
// triple_fifo
// Circular FIFO of value triples with separate read/write pointers that wrap
// modulo DEPTH (DEPTH must be a power of two, >= 2).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din   : write din at the tail (ignored when full without a pop)
//   pop         : drop the head entry (ignored when empty)
//   dout        : head entry
//   dout_next   : entry behind the head (valid when count >= 2)
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
module triple_fifo
  import out_triple_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  triple_t                    din,
  output triple_t                    dout,
  output triple_t                    dout_next,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  triple_t       mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against occupancy; a push into a full FIFO is only legal alongside a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Occupancy flags and head/next-head read ports.
  always_comb begin
    full      = (count == CNT_MAX);
    empty     = (count == {CW{1'b0}});
    dout      = mem[rd_ptr];
    dout_next = mem[rd_ptr + PTR_ONE];
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/out_triple_serializer.sv
// out_triple_serializer
// Captures each new (changed) triple from three 32-bit result buses, queues
// it, and streams it out as three tagged 32-bit words over valid/ready.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   in_out1..in_out3, sample_en : result buses and their valid strobe
//   word_out, word_idx          : serialized word and its source index (0 idle)
//   word_last                   : marks the idx-3 word
//   word_valid, word_ready      : output handshake
//   overflow, drop_count        : sticky drop flag and saturating drop count
//   busy                        : FIFO non-empty or a word in flight
module out_triple_serializer
  import out_triple_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_out1,
  input  logic [31:0]      in_out2,
  input  logic [31:0]      in_out3,
  input  logic             sample_en,
  output logic [31:0]      word_out,
  output logic [1:0]       word_idx,
  output logic             word_last,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1'b1);

  triple_t         cur_triple;
  triple_t         last_triple;
  logic            has_last;
  triple_t         head;
  triple_t         head_next;
  triple_t         next_head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;
  logic            full;
  logic            empty;
  logic            candidate;
  logic            push;
  logic            pop;
  logic            drop;

  ser_state_t      state;
  ser_state_t      state_nx;
  logic [31:0]     word_out_nx;
  logic [1:0]      word_idx_nx;
  logic            word_last_nx;
  logic            word_valid_nx;

  triple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (cur_triple),
    .dout      (head),
    .dout_next (head_next),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Assemble the live bus values into a triple.
  always_comb begin
    cur_triple.out1 = in_out1;
    cur_triple.out2 = in_out2;
    cur_triple.out3 = in_out3;
  end

  // Change detection and push/drop decision; a full FIFO still accepts when the head pops this edge.
  always_comb begin
    if (sample_en && (!has_last || (cur_triple != last_triple))) begin
      candidate = 1'b1;
    end else begin
      candidate = 1'b0;
    end
    pop  = (state == S_SEND3) && word_valid && word_ready;
    push = candidate && (!full || pop);
    drop = candidate && !push;
  end

  // Occupancy after this edge; busy is registered from it so it tracks the FIFO exactly.
  always_comb begin
    case ({push, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  // Entry that becomes the head once the current one pops: the one behind it,
  // or the triple being pushed this very edge when the FIFO held only one.
  always_comb begin
    if (count > CNT_ONE) begin
      next_head = head_next;
    end else begin
      next_head = cur_triple;
    end
  end

  // Serializer next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    word_out_nx   = word_out;
    word_idx_nx   = word_idx;
    word_last_nx  = word_last;
    word_valid_nx = word_valid;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nx      = S_SEND1;
          word_out_nx   = head.out1;
          word_idx_nx   = IDX_1;
          word_last_nx  = 1'b0;
          word_valid_nx = 1'b1;
        end else begin
          state_nx      = S_IDLE;
          word_out_nx   = 32'd0;
          word_idx_nx   = IDX_NONE;
          word_last_nx  = 1'b0;
          word_valid_nx = 1'b0;
        end
      end
      S_SEND1: begin
        if (word_ready) begin
          state_nx    = S_SEND2;
          word_out_nx = head.out2;
          word_idx_nx = IDX_2;
        end else begin
          state_nx = S_SEND1;
        end
      end
      S_SEND2: begin
        if (word_ready) begin
          state_nx     = S_SEND3;
          word_out_nx  = head.out3;
          word_idx_nx  = IDX_3;
          word_last_nx = 1'b1;
        end else begin
          state_nx = S_SEND2;
        end
      end
      S_SEND3: begin
        if (word_ready) begin
          if (count_nx != {CW{1'b0}}) begin
            // Another triple is waiting: start it immediately, no idle bubble.
            state_nx      = S_SEND1;
            word_out_nx   = next_head.out1;
            word_idx_nx   = IDX_1;
            word_last_nx  = 1'b0;
            word_valid_nx = 1'b1;
          end else begin
            state_nx      = S_IDLE;
            word_out_nx   = 32'd0;
            word_idx_nx   = IDX_NONE;
            word_last_nx  = 1'b0;
            word_valid_nx = 1'b0;
          end
        end else begin
          state_nx = S_SEND3;
        end
      end
      default: begin
        state_nx      = S_IDLE;
        word_out_nx   = 32'd0;
        word_idx_nx   = IDX_NONE;
        word_last_nx  = 1'b0;
        word_valid_nx = 1'b0;
      end
    endcase
  end

  // Serializer state and registered output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word_out   <= 32'd0;
      word_idx   <= IDX_NONE;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      word_out   <= word_out_nx;
      word_idx   <= word_idx_nx;
      word_last  <= word_last_nx;
      word_valid <= word_valid_nx;
      busy       <= (count_nx != {CW{1'b0}}) || word_valid_nx;
    end
  end

  // Last-seen triple; updated by every candidate, even a dropped one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_last    <= 1'b0;
      last_triple <= '0;
    end else if (candidate) begin
      has_last    <= 1'b1;
      last_triple <= cur_triple;
    end else begin
      has_last    <= has_last;
      last_triple <= last_triple;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= {CNT_W{1'b0}};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) begin
        drop_count <= drop_count + DROP_ONE;
      end else begin
        drop_count <= drop_count;
      end
    end else begin
      overflow   <= overflow;
      drop_count <= drop_count;
    end
  end

endmodule
